// File: rtl/instr_sequencer.sv
// Instruction sequencer for the Mini TPU front end: a small FIFO of host
// instructions, issued one per cycle and held back while a START computation runs.
module instr_sequencer #(
    parameter  int DEPTH          = 4,
    parameter  int COMPUTE_CYCLES = 11,
    localparam int CW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   in_instr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [15:0]   issue_instr,
    output logic          issue_valid,
    output logic          busy,
    output logic          compute_done,
    output logic [CW-1:0] fifo_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (COMPUTE_CYCLES < 1) ? 1 : $clog2(COMPUTE_CYCLES + 1);

    localparam logic [CW-1:0]    FIFO_FULL = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(COMPUTE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [1:0]       OP_START  = 2'b00;
    localparam logic [1:0]       OP_STOP   = 2'b01;

    typedef enum logic {
        ST_ISSUE   = 1'b0,
        ST_COMPUTE = 1'b1
    } SeqState;

    SeqState          r_state;
    SeqState          w_stateNext;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] w_stallCntNext;

    logic [15:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    logic [15:0]      r_issueInstr;
    logic             r_issueValid;
    logic             r_computeDone;

    logic             w_push;
    logic             w_pop;
    logic             w_doneNext;
    logic             w_fifoEmpty;
    logic             w_fifoFull;
    logic [15:0]      w_head;
    logic [1:0]       w_headOp;

    assign w_head      = r_mem[r_rdPtr];
    assign w_headOp    = w_head[15:14];
    assign w_fifoEmpty = (r_count == '0);
    assign w_fifoFull  = (r_count == FIFO_FULL);

    // Readiness looks only at the registered occupancy, so a pop in the same
    // cycle never opens a slot early.
    assign in_ready = rst_n && !flush && !w_fifoFull;
    assign w_push   = in_valid && in_ready;

    assign busy         = (r_state == ST_COMPUTE);
    assign issue_instr  = r_issueInstr;
    assign issue_valid  = r_issueValid;
    assign compute_done = r_computeDone;
    assign fifo_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ISSUE;
            r_stallCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_stallCnt <= w_stallCntNext;
        end
    end

    // The counter is loaded at the START pop; the last stalled cycle is the
    // one where it holds 1, so the done pulse and the next pop coincide.
    always_comb begin
        w_stateNext    = r_state;
        w_stallCntNext = r_stallCnt;
        w_pop          = 1'b0;
        w_doneNext     = 1'b0;
        if (flush) begin
            w_stateNext    = ST_ISSUE;
            w_stallCntNext = '0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    if (!w_fifoEmpty) begin
                        w_pop = 1'b1;
                        if (w_headOp == OP_START) begin
                            w_stateNext    = ST_COMPUTE;
                            w_stallCntNext = CNT_LOAD;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // A queued STOP wins even on the final stall cycle: abort, no done pulse.
                    if (!w_fifoEmpty && (w_headOp == OP_STOP)) begin
                        w_pop          = 1'b1;
                        w_stateNext    = ST_ISSUE;
                        w_stallCntNext = '0;
                    end else if (r_stallCnt <= CNT_LAST) begin
                        w_stateNext    = ST_ISSUE;
                        w_stallCntNext = '0;
                        w_doneNext     = 1'b1;
                    end else begin
                        w_stallCntNext = r_stallCnt - 1'b1;
                    end
                end
                default: begin
                    w_stateNext    = ST_ISSUE;
                    w_stallCntNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issueInstr  <= '0;
            r_issueValid  <= 1'b0;
            r_computeDone <= 1'b0;
        end else if (flush) begin
            r_issueInstr  <= '0;
            r_issueValid  <= 1'b0;
            r_computeDone <= 1'b0;
        end else begin
            r_issueInstr  <= w_pop ? w_head : 16'h0000;
            r_issueValid  <= w_pop;
            r_computeDone <= w_doneNext;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer, scored against a timestamp-based
// model: a queue of pending words plus the cycle at which the current stall ends.
module tb_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int CC    = 11;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [15:0]   in_instr;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [15:0]   issue_instr;
    logic          issue_valid;
    logic          busy;
    logic          compute_done;
    logic [CW-1:0] fifo_count;

    instr_sequencer #(
        .DEPTH         (DEPTH),
        .COMPUTE_CYCLES(CC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .issue_instr (issue_instr),
        .issue_valid (issue_valid),
        .busy        (busy),
        .compute_done(compute_done),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compareCount = 0;
    int          mismatchCount = 0;

    logic [15:0] modelQ[$];
    int          cyc = 0;
    int          busyUntil = -1;
    int          doneAt = -1;
    logic        expValid = 1'b0;
    logic [15:0] expInstr = 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        busyUntil = -1;
        doneAt    = -1;
        expValid  = 1'b0;
        expInstr  = 16'h0000;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic fl, output logic accepted);
        logic        expReady;
        logic        popped;
        logic [15:0] word;
        in_valid = v;
        in_instr = instr;
        flush    = fl;
        @(negedge clk);
        expReady = !fl && (modelQ.size() < DEPTH);
        checkOutput("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("issue_valid", 32'(issue_valid), 32'(expValid));
        checkOutput("issue_instr", 32'(issue_instr), 32'(expInstr));
        checkOutput("busy", 32'(busy), 32'(cyc <= busyUntil));
        checkOutput("compute_done", 32'(compute_done), 32'(doneAt == cyc));
        popped   = 1'b0;
        word     = 16'h0000;
        accepted = 1'b0;
        if (fl) begin
            modelQ.delete();
            if (busyUntil > cyc) busyUntil = cyc;
            if (doneAt > cyc) doneAt = -1;
        end else begin
            if (modelQ.size() > 0) begin
                if (cyc > busyUntil) begin
                    popped = 1'b1;
                    word   = modelQ.pop_front();
                    if (word[15:14] == 2'b00) begin
                        busyUntil = cyc + CC;
                        doneAt    = cyc + CC + 1;
                    end
                end else if (modelQ[0][15:14] == 2'b01) begin
                    popped    = 1'b1;
                    word      = modelQ.pop_front();
                    busyUntil = cyc;
                    doneAt    = -1;
                end
            end
            if (v && expReady) begin
                modelQ.push_back(instr);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        expValid = popped;
        expInstr = popped ? word : 16'h0000;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0, acc);
    endtask

    task automatic push(input logic [15:0] w);
        logic acc;
        applyStimulus(1'b1, w, 1'b0, acc);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic applyReset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("rst_issue_instr", 32'(issue_instr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_compute_done", 32'(compute_done), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        logic [15:0] pending[$];
        int          budget;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        applyReset();

        push(16'h8507); push(16'hA30C); push(16'hC100);
        idle(6);

        push(16'h0000); push(16'h8001);
        idle(CC + 6);

        push(16'h0000); idle(2); push(16'h4000);
        idle(6);

        // Over-fill during a computation; refused words are re-offered until accepted.
        push(16'h0000);
        for (int i = 0; i < 5; i++) pending.push_back(16'h8010 + 16'(i));
        budget = 60;
        while (pending.size() > 0 && budget > 0) begin
            applyStimulus(1'b1, pending[0], 1'b0, acc);
            if (acc) void'(pending.pop_front());
            budget--;
        end
        checkOutput("fill_drain_budget", 32'(pending.size()), 32'd0);
        idle(4);

        push(16'h0000); push(16'h8101); push(16'h8202); push(16'h8303);
        applyStimulus(1'b1, 16'h4000, 1'b1, acc);
        idle(3);
        push(16'h8123);
        idle(4);

        push(16'h0000); push(16'h8401); push(16'h8502);
        idle(2);
        applyReset();
        idle(5);
        push(16'h8600);
        idle(3);

        for (int n = 0; n < 1500; n++) begin
            int          sel;
            logic [15:0] w;
            sel = int'($urandom_range(0, 9));
            w   = 16'($urandom());
            case (sel)
                0:       w[15:14] = 2'b00;
                1, 2:    w[15:14] = 2'b01;
                3, 4, 5: w[15:14] = 2'b10;
                default: w[15:14] = 2'b11;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                applyReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 9) < 6), w, 1'($urandom_range(0, 39) == 0), acc);
            end
        end
        idle(CC + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
